// File: rtl/mult_req_arbiter.sv
// Round-robin arbiter that time-shares one W x W unsigned multiplier among NREQ requesters.
// Optional WAIT watchdog is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     ack,
    output logic [2*W-1:0]      res,
    output logic                err,
    output logic                busy,
    output logic                mul_rst,
    output logic                mul_start,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_res
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_grant;
    logic [W-1:0]       r_opa;
    logic [W-1:0]       r_opb;

    logic [NREQ-1:0]    r_ack;
    logic [2*W-1:0]     r_res;
    logic               r_err;
    logic               r_busy;
    logic               r_mul_rst;
    logic               r_mul_start;
    logic [W-1:0]       r_mul_a;
    logic [W-1:0]       r_mul_b;

    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_win;
    logic               w_found;
    logic               w_grant_en;
    logic               w_timeout;

    logic [IW-1:0]      w_ptr_nxt;
    logic [NREQ-1:0]    w_ack_nxt;
    logic [2*W-1:0]     w_res_nxt;
    logic               w_err_nxt;
    logic               w_busy_nxt;
    logic               w_mul_rst_nxt;
    logic               w_mul_start_nxt;
    logic [W-1:0]       w_mul_a_nxt;
    logic [W-1:0]       w_mul_b_nxt;

    logic [W-1:0]       w_a_arr [NREQ];
    logic [W-1:0]       w_b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = req_a[gi*W +: W];
        assign w_b_arr[gi] = req_b[gi*W +: W];
    end

    // Cyclic search starting one past the last winner
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_grant_en = (r_state == S_IDLE) && w_found;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_cnt <= '0;
        end else if (!mul_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !mul_done && (r_cnt == CW'(TIMEOUT - 1));
`else
    // TIMEOUT has no effect without the watchdog
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_CLR;
            S_CLR:   w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT:  if (mul_done || w_timeout) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are derived from the next state so that every port is a flop
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_ack_nxt       = '0;
        w_res_nxt       = r_res;
        w_err_nxt       = 1'b0;
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_mul_rst_nxt   = (w_state_nxt == S_CLR);
        w_mul_start_nxt = (w_state_nxt == S_START);
        w_mul_a_nxt     = '0;
        w_mul_b_nxt     = '0;
        if (w_grant_en) begin
            w_ptr_nxt = w_win;
        end
        if (w_state_nxt == S_START || w_state_nxt == S_WAIT) begin
            w_mul_a_nxt = r_opa;
            w_mul_b_nxt = r_opb;
        end
        if (r_state == S_WAIT && w_state_nxt == S_DONE) begin
            w_ack_nxt = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
            w_res_nxt = w_timeout ? '0 : mul_res;
            w_err_nxt = w_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= IW'(NREQ - 1);
            r_ack       <= '0;
            r_res       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mul_rst   <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_ack       <= w_ack_nxt;
            r_res       <= w_res_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_mul_rst   <= w_mul_rst_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_mul_a     <= w_mul_a_nxt;
            r_mul_b     <= w_mul_b_nxt;
        end
    end

    // Winner index and operands are captured once, at grant time
    always_ff @(posedge clk) begin
        if (w_grant_en) begin
            r_grant <= w_win;
            r_opa   <= w_a_arr[w_win];
            r_opb   <= w_b_arr[w_win];
        end
    end

    assign ack       = r_ack;
    assign res       = r_res;
    assign err       = r_err;
    assign busy      = r_busy;
    assign mul_rst   = r_mul_rst;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_req_arbiter.sv
// Directed bench for mult_req_arbiter with a sticky-done multiplier stub of adjustable latency.
// The watchdog test is compiled only when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_req_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*W-1:0]   req_a = '0;
    logic [NREQ*W-1:0]   req_b = '0;
    logic [NREQ-1:0]     ack;
    logic [2*W-1:0]      res;
    logic                err;
    logic                busy;
    logic                mul_rst;
    logic                mul_start;
    logic [W-1:0]        mul_a;
    logic [W-1:0]        mul_b;
    logic                mul_done;
    logic [2*W-1:0]      mul_res;

    int n_chk  = 0;
    int n_fail = 0;

    // multiplier stub
    logic            s_done  = 1'b0;
    logic            s_run   = 1'b0;
    int              s_cnt   = 0;
    logic [2*W-1:0]  s_prod  = '0;
    logic [2*W-1:0]  s_res   = '0;
    int              lat     = 0;
    logic            stub_en = 1'b1;

    assign mul_done = s_done;
    assign mul_res  = s_res;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_rst) begin
            s_done <= 1'b0;
            s_run  <= 1'b0;
            s_cnt  <= 0;
        end else if (mul_start) begin
            s_run  <= 1'b1;
            s_cnt  <= lat;
            s_prod <= {16'b0, mul_a} * {16'b0, mul_b};
        end else if (s_run && !s_done && stub_en) begin
            if (s_cnt == 0) begin
                s_done <= 1'b1;
                s_res  <= s_prod;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    mult_req_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .ack       (ack),
        .res       (res),
        .err       (err),
        .busy      (busy),
        .mul_rst   (mul_rst),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_res   (mul_res)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // Counts negedges until an ack appears; gives up after 60
    task automatic wait_ack(output logic [NREQ-1:0] a, output int n);
        a = '0;
        n = 0;
        while (a == '0 && n < 60) begin
            @(negedge clk);
            n++;
            a = ack;
        end
        if (a == '0) check_eq("ack_timeout", 64'd0, 64'd1);
    endtask

    logic [NREQ-1:0] a;
    int              n;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] e_ack2 [3];
    logic [31:0]     e_res2 [3];
    logic [NREQ-1:0] e_ack3 [4];
    logic [31:0]     e_res3 [4];

    initial begin
        e_ack2 = '{4'b0001, 4'b0010, 4'b0100};
        e_res2 = '{32'h01F403BF, 32'h00007E81, 32'h423E1899};
        e_ack3 = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        e_res3 = '{32'h000F4240, 32'h0000000F, 32'h000F4240, 32'h0000000F};

        // reset values
        repeat (3) @(negedge clk);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_res", res, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mulrst", mul_rst, 0);
        check_eq("rst_mulstart", mul_start, 0);
        check_eq("rst_mula", mul_a, 0);
        check_eq("rst_mulb", mul_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // single request, max operands, protocol timing
        lat = 0;
        set_op(0, 16'hFFFF, 16'hFFFF);
        req = 4'b0001;
        @(negedge clk);
        check_eq("t1_mulrst", mul_rst, 1);
        check_eq("t1_start_lo", mul_start, 0);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_mula_clr", mul_a, 0);
        @(negedge clk);
        check_eq("t1_mulstart", mul_start, 1);
        check_eq("t1_rst_lo", mul_rst, 0);
        check_eq("t1_mula", mul_a, 16'hFFFF);
        check_eq("t1_mulb", mul_b, 16'hFFFF);
        set_op(0, 16'h0000, 16'h0000);
        wait_ack(a, n);
        check_eq("t1_lat", n, 3);
        check_eq("t1_ack", a, 4'b0001);
        check_eq("t1_res", res, 32'hFFFE0001);
        check_eq("t1_err", err, 0);
        req = 4'b0000;
        @(negedge clk);
        check_eq("t1_ack_pulse", ack, 0);
        check_eq("t1_idle", busy, 0);
        check_eq("t1_res_hold", res, 32'hFFFE0001);
        check_eq("t1_mula_idle", mul_a, 0);

        // three simultaneous requesters from a fresh pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = 1;
        set_op(0, 16'd11903, 16'd2753);
        set_op(1, 16'd127, 16'd255);
        set_op(2, 16'h4B73, 16'hE0C3);
        req = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            wait_ack(a, n);
            check_eq("rr_ack", a, e_ack2[k]);
            check_eq("rr_res", res, e_res2[k]);
            req = req & ~a;
            @(negedge clk);
            check_eq("rr_pulse", ack, 0);
        end

        // requesters 1 and 3 both hold req: grants must alternate
        lat = 0;
        set_op(1, 16'd3, 16'd5);
        set_op(3, 16'd1000, 16'd1000);
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, n);
            check_eq("alt_ack", a, e_ack3[k]);
            check_eq("alt_res", res, e_res3[k]);
            if (k == 3) req = 4'b0000;
        end
        @(negedge clk);
        check_eq("alt_end", ack, 0);

        // reset in the middle of WAIT drops the operation
        stub_en = 1'b0;
        set_op(2, 16'd200, 16'd300);
        req = 4'b0100;
        repeat (5) @(negedge clk);
        check_eq("w_busy", busy, 1);
        check_eq("w_mula", mul_a, 16'd200);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        check_eq("wr_busy", busy, 0);
        check_eq("wr_res", res, 0);
        check_eq("wr_mula", mul_a, 0);
        check_eq("wr_mulstart", mul_start, 0);
        acc = '0;
        repeat (6) begin
            @(negedge clk);
            acc = acc | ack;
        end
        check_eq("wr_noack", acc, 0);
        stub_en = 1'b1;
        req = 4'b0100;
        wait_ack(a, n);
        check_eq("wr2_lat", n, 5);
        check_eq("wr2_ack", a, 4'b0100);
        check_eq("wr2_res", res, 32'h0000EA60);
        req = 4'b0000;
        @(negedge clk);

        // stale done from the previous operation must not complete this one
        check_eq("stale_pre", mul_done, 1);
        lat = 6;
        set_op(0, 16'd2, 16'd3);
        req = 4'b0001;
        wait_ack(a, n);
        check_eq("stale_lat", n, 11);
        check_eq("stale_ack", a, 4'b0001);
        check_eq("stale_res", res, 32'd6);
        req = 4'b0000;
        @(negedge clk);

`ifdef MULT_ARB_TIMEOUT_EN
        // multiplier never answers: watchdog completes with err
        stub_en = 1'b0;
        set_op(1, 16'd7, 16'd7);
        req = 4'b0010;
        wait_ack(a, n);
        check_eq("to_lat", n, 11);
        check_eq("to_ack", a, 4'b0010);
        check_eq("to_err", err, 1);
        check_eq("to_res", res, 0);
        req = 4'b0000;
        @(negedge clk);
        check_eq("to_idle", busy, 0);
        check_eq("to_err_pulse", err, 0);
        stub_en = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
